// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the accumulator CPU: datapath widths, the opcode map
// used by both the sequencer and the ALU, and the sequencer state type.
package cpu_pkg;

  localparam int OPCODE_WIDTH   = 4;
  localparam int REGISTER_WIDTH = 8;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int INSTR_WIDTH    = OPCODE_WIDTH + REGISTER_WIDTH;
  localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP       = 4'd0;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD       = 4'd1;
  localparam logic [OPCODE_WIDTH-1:0] OP_INCREMENT = 4'd2;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND       = 4'd3;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR        = 4'd4;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD      = 4'd5;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE     = 4'd6;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI       = 4'd7;
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP      = 4'd8;
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ        = 4'd9;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT      = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALTED
  } seq_state_t;

  // Opcodes whose result comes back from the external ALU into the accumulator.
  function automatic logic isAluOp(input logic [OPCODE_WIDTH-1:0] op);
    return (op == OP_ADD) || (op == OP_INCREMENT) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/register_file.sv
// register_file
// General-purpose register storage for the accumulator CPU.
// Ports:
//   clock    - rising-edge clock
//   resetN   - asynchronous active-low reset, clears every register
//   i_we     - write enable, write lands on the next rising edge
//   i_waddr  - write register index
//   i_wdata  - write data
//   i_raddr  - read register index
//   o_rdata  - combinational read data (shows the pre-write value during a write cycle)
module register_file
  import cpu_pkg::*;
(
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      i_we,
  input  logic [REG_ADDR_WIDTH-1:0] i_waddr,
  input  logic [REGISTER_WIDTH-1:0] i_wdata,
  input  logic [REG_ADDR_WIDTH-1:0] i_raddr,
  output logic [REGISTER_WIDTH-1:0] o_rdata
);

  logic [REGISTER_WIDTH-1:0] r_regs [NUM_REGS];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_regs[i_raddr];

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
// Fetch/decode/execute controller for the accumulator CPU. Owns the program
// counter, accumulator and register file; arithmetic goes through the external
// combinational ALU via opCode/registerValue/accumulator -> aluResult.
// Ports:
//   clock         - rising-edge clock
//   resetN        - asynchronous active-low reset
//   run           - start/continue execution
//   progAddr      - program memory address (the PC)
//   progData      - program memory data, valid one cycle after progAddr
//   opCode        - to ALU, NOP outside EXECUTE
//   registerValue - to ALU, contents of the register selected by the operand
//   accumulator   - to ALU and debug
//   aluResult     - from ALU
//   instrDone     - one-cycle pulse when an instruction retires
//   halted        - high once a HALT has executed
module instruction_sequencer
  import cpu_pkg::*;
(
  input  logic                      clock,
  input  logic                      resetN,
  input  logic                      run,
  output logic [REGISTER_WIDTH-1:0] progAddr,
  input  logic [INSTR_WIDTH-1:0]    progData,
  output logic [OPCODE_WIDTH-1:0]   opCode,
  output logic [REGISTER_WIDTH-1:0] registerValue,
  output logic [REGISTER_WIDTH-1:0] accumulator,
  input  logic [REGISTER_WIDTH-1:0] aluResult,
  output logic                      instrDone,
  output logic                      halted
);

  seq_state_t r_state;
  seq_state_t w_stateNext;

  logic [REGISTER_WIDTH-1:0] r_pc;
  logic [REGISTER_WIDTH-1:0] r_acc;
  logic [INSTR_WIDTH-1:0]    r_instr;

  logic [REGISTER_WIDTH-1:0] w_pcNext;
  logic [REGISTER_WIDTH-1:0] w_pcInc;
  logic [REGISTER_WIDTH-1:0] w_accNext;
  logic                      w_instrLoad;
  logic                      w_regWe;
  logic                      w_instrDone;
  logic [OPCODE_WIDTH-1:0]   w_opCode;

  logic [OPCODE_WIDTH-1:0]   w_latchedOp;
  logic [REGISTER_WIDTH-1:0] w_operand;
  logic [REG_ADDR_WIDTH-1:0] w_regIndex;
  logic [REGISTER_WIDTH-1:0] w_regData;

  assign w_latchedOp = r_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign w_operand   = r_instr[REGISTER_WIDTH-1:0];
  assign w_regIndex  = w_operand[REG_ADDR_WIDTH-1:0];
  // PC wraps naturally at the register width.
  assign w_pcInc     = r_pc + REGISTER_WIDTH'(1);

  register_file u_registerFile (
    .clock   (clock),
    .resetN  (resetN),
    .i_we    (w_regWe),
    .i_waddr (w_regIndex),
    .i_wdata (r_acc),
    .i_raddr (w_regIndex),
    .o_rdata (w_regData)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_pc    <= '0;
      r_acc   <= '0;
      r_instr <= '0;
    end else begin
      r_pc  <= w_pcNext;
      r_acc <= w_accNext;
      if (w_instrLoad) begin
        r_instr <= progData;
      end
    end
  end

  // Memory read is synchronous: the address presented in FETCH returns its
  // word during DECODE, which is the only cycle progData is captured.
  always_comb begin
    w_stateNext = r_state;
    w_pcNext    = r_pc;
    w_accNext   = r_acc;
    w_instrLoad = 1'b0;
    w_regWe     = 1'b0;
    w_instrDone = 1'b0;
    w_opCode    = OP_NOP;

    unique case (r_state)
      S_IDLE: begin
        if (run) begin
          w_stateNext = S_FETCH;
        end
      end

      S_FETCH: begin
        w_stateNext = S_DECODE;
      end

      S_DECODE: begin
        w_instrLoad = 1'b1;
        w_stateNext = S_EXECUTE;
      end

      S_EXECUTE: begin
        w_opCode = w_latchedOp;
        if (w_latchedOp == OP_HALT) begin
          w_stateNext = S_HALTED;
        end else begin
          w_instrDone = 1'b1;
          w_pcNext    = w_pcInc;
          w_stateNext = run ? S_FETCH : S_IDLE;
          if (isAluOp(w_latchedOp)) begin
            w_accNext = aluResult;
          end
          // Undefined opcodes fall through to the defaults and behave as NOP.
          case (w_latchedOp)
            OP_LOAD:  w_accNext = w_regData;
            OP_STORE: w_regWe   = 1'b1;
            OP_LDI:   w_accNext = w_operand;
            OP_JUMP:  w_pcNext  = w_operand;
            OP_JZ: begin
              if (r_acc == '0) begin
                w_pcNext = w_operand;
              end
            end
            default: ;
          endcase
        end
      end

      S_HALTED: begin
        w_stateNext = S_HALTED;
      end

      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  assign progAddr      = r_pc;
  assign opCode        = w_opCode;
  assign registerValue = w_regData;
  assign accumulator   = r_acc;
  assign instrDone     = w_instrDone;
  assign halted        = (r_state == S_HALTED);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: a model program memory and model ALU wrap
// the DUT; small programs are listed in a table with their expected final
// accumulator, PC and retire count, followed by hand-written cycle sequences
// for run drop, reset mid-EXECUTE, opCode gating and store/read ordering.
module tb_instruction_sequencer;
  import cpu_pkg::*;

  logic                      clock = 1'b0;
  logic                      resetN;
  logic                      run;
  logic [REGISTER_WIDTH-1:0] progAddr;
  logic [INSTR_WIDTH-1:0]    progData;
  logic [OPCODE_WIDTH-1:0]   opCode;
  logic [REGISTER_WIDTH-1:0] registerValue;
  logic [REGISTER_WIDTH-1:0] accumulator;
  logic [REGISTER_WIDTH-1:0] aluResult;
  logic                      instrDone;
  logic                      halted;

  int total = 0;
  int bad   = 0;

  logic [INSTR_WIDTH-1:0] progMem [256];

  typedef struct {
    logic [7:0][19:0] pairs;
    int               n;
    logic [7:0]       expAcc;
    logic [7:0]       expPc;
    int               expDone;
  } vec_t;

  localparam int NUM_VECS = 8;
  vec_t vecs [NUM_VECS];

  instruction_sequencer dut (
    .clock         (clock),
    .resetN        (resetN),
    .run           (run),
    .progAddr      (progAddr),
    .progData      (progData),
    .opCode        (opCode),
    .registerValue (registerValue),
    .accumulator   (accumulator),
    .aluResult     (aluResult),
    .instrDone     (instrDone),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  // Synchronous-read program memory.
  always @(posedge clock) begin
    progData <= progMem[progAddr];
  end

  // Reference ALU, results truncated to 8 bits.
  always_comb begin
    case (opCode)
      OP_ADD:       aluResult = accumulator + registerValue;
      OP_INCREMENT: aluResult = accumulator + 8'd1;
      OP_AND:       aluResult = accumulator & registerValue;
      OP_OR:        aluResult = accumulator | registerValue;
      default:      aluResult = accumulator;
    endcase
  end

  // Retire monitor: counts instrDone pulses and flags any gap other than 3
  // cycles between consecutive pulses since the last reset.
  int doneCount = 0;
  int gapErr    = 0;
  int sinceLast = 0;
  bit havePrev  = 1'b0;

  always @(negedge clock) begin
    if (!resetN) begin
      havePrev  <= 1'b0;
      sinceLast <= 0;
    end else if (instrDone) begin
      if (havePrev && (sinceLast + 1 != 3)) begin
        gapErr <= gapErr + 1;
      end
      havePrev  <= 1'b1;
      sinceLast <= 0;
      doneCount <= doneCount + 1;
    end else begin
      sinceLast <= sinceLast + 1;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion, want completion before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin
      progMem[i] = {OP_HALT, 8'h00};
    end
  endtask

  task automatic putWord(input logic [7:0] addr, input logic [3:0] op, input logic [7:0] operand);
    progMem[addr] = {op, operand};
  endtask

  task automatic doReset();
    resetN = 1'b0;
    run    = 1'b0;
    tick();
    tick();
  endtask

  task automatic waitDone(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (instrDone) seen = 1'b1;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  task automatic waitHalt(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (halted) seen = 1'b1;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  task automatic addWord(input int v, input logic [7:0] addr, input logic [3:0] op, input logic [7:0] operand);
    vecs[v].pairs[vecs[v].n] = {addr, op, operand};
    vecs[v].n++;
  endtask

  task automatic setExp(input int v, input logic [7:0] acc, input logic [7:0] pc, input int done);
    vecs[v].expAcc  = acc;
    vecs[v].expPc   = pc;
    vecs[v].expDone = done;
  endtask

  task automatic fillTable();
    for (int v = 0; v < NUM_VECS; v++) begin
      vecs[v].n     = 0;
      vecs[v].pairs = '0;
    end
    // Basic program: 5 + 3.
    addWord(0, 8'h00, OP_LDI, 8'h05); addWord(0, 8'h01, OP_STORE, 8'h01);
    addWord(0, 8'h02, OP_LDI, 8'h03); addWord(0, 8'h03, OP_ADD, 8'h01);
    addWord(0, 8'h04, OP_HALT, 8'h00);
    setExp(0, 8'h08, 8'h04, 4);
    // INCREMENT of 255 wraps to 0, JZ taken.
    addWord(1, 8'h00, OP_LDI, 8'hFF); addWord(1, 8'h01, OP_INCREMENT, 8'h00);
    addWord(1, 8'h02, OP_JZ, 8'h10);  addWord(1, 8'h10, OP_HALT, 8'h00);
    setExp(1, 8'h00, 8'h10, 3);
    // JZ not taken.
    addWord(2, 8'h00, OP_LDI, 8'h01); addWord(2, 8'h01, OP_JZ, 8'h10);
    addWord(2, 8'h02, OP_HALT, 8'h00); addWord(2, 8'h10, OP_LDI, 8'h77);
    setExp(2, 8'h01, 8'h02, 2);
    // JUMP to 0xFF, NOP there wraps PC to 0, JZ then falls through to HALT.
    addWord(3, 8'h00, OP_JZ, 8'h02);   addWord(3, 8'h01, OP_HALT, 8'h00);
    addWord(3, 8'h02, OP_INCREMENT, 8'h00); addWord(3, 8'h03, OP_JUMP, 8'hFF);
    addWord(3, 8'hFF, OP_NOP, 8'h00);
    setExp(3, 8'h01, 8'h01, 5);
    // AND / OR through registers.
    addWord(4, 8'h00, OP_LDI, 8'hF0); addWord(4, 8'h01, OP_STORE, 8'h03);
    addWord(4, 8'h02, OP_LDI, 8'h3C); addWord(4, 8'h03, OP_AND, 8'h03);
    addWord(4, 8'h04, OP_STORE, 8'h06); addWord(4, 8'h05, OP_LDI, 8'h05);
    addWord(4, 8'h06, OP_OR, 8'h06);  addWord(4, 8'h07, OP_HALT, 8'h00);
    setExp(4, 8'h35, 8'h07, 7);
    // Register index taken from the low operand bits only (0xFF -> r7).
    addWord(5, 8'h00, OP_LDI, 8'h99); addWord(5, 8'h01, OP_STORE, 8'hFF);
    addWord(5, 8'h02, OP_LDI, 8'h00); addWord(5, 8'h03, OP_LOAD, 8'h07);
    addWord(5, 8'h04, OP_HALT, 8'h00);
    setExp(5, 8'h99, 8'h04, 4);
    // Undefined opcodes behave as NOP.
    addWord(6, 8'h00, OP_LDI, 8'h21); addWord(6, 8'h01, 4'hA, 8'h33);
    addWord(6, 8'h02, 4'hE, 8'h00);   addWord(6, 8'h03, OP_HALT, 8'h00);
    setExp(6, 8'h21, 8'h03, 3);
    // Plain NOP.
    addWord(7, 8'h00, OP_NOP, 8'h00); addWord(7, 8'h01, OP_HALT, 8'h00);
    setExp(7, 8'h00, 8'h01, 1);
  endtask

  task automatic applyStimulus(input int v);
    int d0;
    int g0;
    doReset();
    clearMem();
    for (int j = 0; j < vecs[v].n; j++) begin
      progMem[vecs[v].pairs[j][19:12]] = vecs[v].pairs[j][11:0];
    end
    d0 = doneCount;
    g0 = gapErr;
    resetN = 1'b1;
    run    = 1'b1;
    waitHalt($sformatf("v%0d_halt", v), 200);
    checkOutput($sformatf("v%0d_acc", v), 32'(accumulator), 32'(vecs[v].expAcc));
    checkOutput($sformatf("v%0d_pc", v), 32'(progAddr), 32'(vecs[v].expPc));
    checkOutput($sformatf("v%0d_done", v), doneCount - d0, vecs[v].expDone);
    checkOutput($sformatf("v%0d_gap", v), gapErr - g0, 0);
    resetN = 1'b0;
    #1;
    checkOutput($sformatf("v%0d_halt_async_clear", v), 32'(halted), 32'd0);
    run = 1'b0;
  endtask

  initial begin
    resetN = 1'b0;
    run    = 1'b0;
    clearMem();
    fillTable();
    tick();
    tick();

    checkOutput("rst_pc", 32'(progAddr), 32'd0);
    checkOutput("rst_acc", 32'(accumulator), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_done", 32'(instrDone), 32'd0);
    checkOutput("rst_opcode", 32'(opCode), 32'(OP_NOP));
    checkOutput("rst_regval", 32'(registerValue), 32'd0);

    // IDLE with run low must not fetch.
    resetN = 1'b1;
    repeat (4) tick();
    checkOutput("idle_pc", 32'(progAddr), 32'd0);
    checkOutput("idle_done", 32'(instrDone), 32'd0);

    for (int v = 0; v < NUM_VECS; v++) begin
      applyStimulus(v);
    end

    // run dropped during DECODE of the second instruction.
    doReset();
    clearMem();
    putWord(8'h00, OP_LDI, 8'h11); putWord(8'h01, OP_LDI, 8'h22);
    putWord(8'h02, OP_LDI, 8'h33); putWord(8'h03, OP_HALT, 8'h00);
    resetN = 1'b1;
    run    = 1'b1;
    waitDone("h1_first", 20);
    tick();
    tick();
    run = 1'b0;
    tick();
    checkOutput("h1_retire", 32'(instrDone), 32'd1);
    tick();
    checkOutput("h1_idle_done", 32'(instrDone), 32'd0);
    checkOutput("h1_idle_pc", 32'(progAddr), 32'd2);
    checkOutput("h1_idle_acc", 32'(accumulator), 32'h22);
    repeat (3) tick();
    checkOutput("h1_hold_pc", 32'(progAddr), 32'd2);
    checkOutput("h1_hold_done", 32'(instrDone), 32'd0);
    run = 1'b1;
    waitHalt("h1_halt", 20);
    checkOutput("h1_resume_acc", 32'(accumulator), 32'h33);
    checkOutput("h1_resume_pc", 32'(progAddr), 32'd3);

    // Reset pulled during EXECUTE of STORE r2.
    doReset();
    clearMem();
    putWord(8'h00, OP_LDI, 8'h5A); putWord(8'h01, OP_STORE, 8'h02);
    putWord(8'h02, OP_HALT, 8'h00);
    resetN = 1'b1;
    run    = 1'b1;
    waitDone("h2_first", 20);
    tick();
    tick();
    tick();
    checkOutput("h2_store_exec", 32'(instrDone), 32'd1);
    resetN = 1'b0;
    #1;
    checkOutput("h2_async_acc", 32'(accumulator), 32'd0);
    checkOutput("h2_async_done", 32'(instrDone), 32'd0);
    checkOutput("h2_async_pc", 32'(progAddr), 32'd0);
    checkOutput("h2_async_halted", 32'(halted), 32'd0);
    checkOutput("h2_async_opcode", 32'(opCode), 32'(OP_NOP));
    tick();
    clearMem();
    putWord(8'h00, OP_LDI, 8'h77); putWord(8'h01, OP_LOAD, 8'h02);
    putWord(8'h02, OP_HALT, 8'h00);
    resetN = 1'b1;
    waitHalt("h2_halt", 20);
    checkOutput("h2_r2_clear", 32'(accumulator), 32'd0);

    // opCode visible only in EXECUTE, including undefined opcodes.
    doReset();
    clearMem();
    putWord(8'h00, OP_LDI, 8'h21); putWord(8'h01, 4'hA, 8'h33);
    putWord(8'h02, OP_HALT, 8'h00);
    resetN = 1'b1;
    run    = 1'b1;
    tick();
    checkOutput("h3_op_fetch0", 32'(opCode), 32'(OP_NOP));
    tick();
    checkOutput("h3_op_decode0", 32'(opCode), 32'(OP_NOP));
    tick();
    checkOutput("h3_op_exec_ldi", 32'(opCode), 32'(OP_LDI));
    tick();
    checkOutput("h3_op_fetch1", 32'(opCode), 32'(OP_NOP));
    tick();
    checkOutput("h3_op_decode1", 32'(opCode), 32'(OP_NOP));
    tick();
    checkOutput("h3_op_exec_undef", 32'(opCode), 32'hA);
    checkOutput("h3_undef_done", 32'(instrDone), 32'd1);
    tick();
    checkOutput("h3_op_after", 32'(opCode), 32'(OP_NOP));
    checkOutput("h3_acc", 32'(accumulator), 32'h21);
    checkOutput("h3_pc", 32'(progAddr), 32'd2);

    // STORE shows the old register value during its own EXECUTE.
    doReset();
    clearMem();
    putWord(8'h00, OP_LDI, 8'h44); putWord(8'h01, OP_STORE, 8'h04);
    putWord(8'h02, OP_LOAD, 8'h04); putWord(8'h03, OP_HALT, 8'h00);
    resetN = 1'b1;
    run    = 1'b1;
    waitDone("h4_first", 20);
    repeat (3) tick();
    checkOutput("h4_store_done", 32'(instrDone), 32'd1);
    checkOutput("h4_old_value", 32'(registerValue), 32'd0);
    repeat (3) tick();
    checkOutput("h4_new_value", 32'(registerValue), 32'h44);
    waitHalt("h4_halt", 20);
    checkOutput("h4_acc", 32'(accumulator), 32'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Fetch/decode/execute controller for the accumulator CPU. It drives the ALU's opCode and registerValue inputs and consumes aluResult.
- Owns the program counter, the accumulator and the register file.
- Fetches instruction words from a synchronous-read program memory.
- Handles load/store/jump/halt itself; arithmetic is delegated to the combinational ALU.

Parameters:
OPCODE_WIDTH, 4, opcode field width
REGISTER_WIDTH, 8, data, accumulator and PC width
REG_ADDR_WIDTH, 3, register index width (8 registers)
INSTR_WIDTH, OPCODE_WIDTH+REGISTER_WIDTH (12), instruction word: opcode in [11:8], operand in [7:0]

Ports:
clock  input  1  rising-edge clock
resetN  input  1  asynchronous active-low reset
run  input  1  start/continue execution
progAddr  output  REGISTER_WIDTH  program memory address (= PC)
progData  input  INSTR_WIDTH  program memory data, valid 1 cycle after progAddr
opCode  output  OPCODE_WIDTH  to ALU
registerValue  output  REGISTER_WIDTH  to ALU: selected register contents
accumulator  output  REGISTER_WIDTH  to ALU and debug
aluResult  input  REGISTER_WIDTH  from ALU, combinational
instrDone  output  1  one-cycle pulse when an instruction retires
halted  output  1  high in HALTED state

Behaviour:
- Reset: one clock (clock); reset is asynchronous and active-low (resetN).
  - While resetN=0: state IDLE; PC, accumulator, all registers, instruction latch, instrDone and halted = 0; opCode = NOP.
- Opcodes (shared package): NOP=0, ADD=1, INCREMENT=2, AND=3, OR=4, LOAD=5, STORE=6, LDI=7, JUMP=8, JZ=9, HALT=15. Undefined codes execute as NOP.
- Operand usage: register index = operand[REG_ADDR_WIDTH-1:0]; immediate and jump target = operand[7:0].
- FSM states: IDLE, FETCH, DECODE, EXECUTE, HALTED.
  - IDLE: progAddr=PC. If run=1, go to FETCH.
  - FETCH: progAddr=PC. Go to DECODE unconditionally.
  - DECODE: latch progData into the instruction register. Go to EXECUTE.
  - EXECUTE:
    - opCode = latched opcode; registerValue = reg[index].
    - ADD/INCREMENT/AND/OR: accumulator <= aluResult.
    - LOAD: accumulator <= reg[index].
    - STORE: reg[index] <= accumulator.
    - LDI: accumulator <= immediate.
    - JUMP: PC <= target.
    - JZ: PC <= target if accumulator==0, else PC+1.
    - All non-jump instructions: PC <= PC+1.
    - HALT: PC unchanged; go to HALTED.
    - Otherwise instrDone=1 for this cycle; next state FETCH if run=1, else IDLE.
  - HALTED: halted=1. Exit only via reset.
- opCode = NOP in every state other than EXECUTE, so the ALU passes the accumulator through.
- Latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE). First fetch occurs the cycle after run is seen high in IDLE.
- PC arithmetic is modulo 2^REGISTER_WIDTH: 255+1 wraps to 0, no flag.
- ALU result is truncated to REGISTER_WIDTH with no carry kept; INCREMENT of 255 gives 0.
- run deasserted mid-instruction: the current instruction completes through EXECUTE, then IDLE. PC is preserved, and run reasserted resumes at PC.
- STORE to the register being read: the write lands at the clock edge. registerValue in the same EXECUTE cycle shows the old value.
- Reset asserted mid-EXECUTE: no write takes effect; all state cleared immediately.
- progData is sampled only in DECODE. It is don't-care in all other states.

Decomposition:
- Package cpu_pkg holds the opcode constants, OPCODE_WIDTH/REGISTER_WIDTH/REG_ADDR_WIDTH/INSTR_WIDTH, and the state enum typedef.
- Sub-module register_file: 2^REG_ADDR_WIDTH x REGISTER_WIDTH storage.
  - One combinational read port and one synchronous write port (we, waddr, wdata).
  - Async active-low reset to zero.
- Top-level instruction_sequencer instantiates register_file. The ALU is connected at the CPU top, outside this block.

Test Plan:
1. Program LDI 5; STORE r1; LDI 3; ADD r1; HALT, with a model ALU -> accumulator=8 after ADD, halted=1, progAddr=4, 4 instrDone pulses, 3 cycles apart.
2. LDI 255; INCREMENT; JZ 0x10 -> accumulator=0, and the next fetch address is 0x10.
3. LDI 1; JZ 0x10 -> branch not taken, next progAddr=2. Also JUMP 0xFF with NOP at 0xFF -> the next fetch after it is address 0x00 (wrap).
4. Drop run during DECODE of instruction 1 -> it still retires (instrDone=1), FSM goes to IDLE with PC=2. Reassert run -> fetch from 2.
5. Pull resetN low during EXECUTE of a STORE r2 -> r2 remains 0, accumulator=0, state IDLE, halted=0 immediately, without waiting for a clock edge.
6. Undefined opcode 0xA with operand 0x33 -> accumulator unchanged, PC+1, opCode output shows 0xA only during EXECUTE and NOP otherwise.
